// File: rtl/datapath.sv
`timescale 1ns/1ps
// datapath -- single-bus 32-bit register datapath with a combinational ALU.
//
// Purpose:
//   A shared 32-bit bus is driven by one prioritised register source. PC, MAR,
//   MDR, IR, Y, R3, R4 and R7 load from that bus. MDR can load from memory
//   instead. Z (ZHI/ZLO) captures the 64-bit ALU result of Y (op A) and the
//   bus (op B).
//
// Ports:
//   clk                      rising-edge clock
//   clr                      asynchronous active-high clear of all registers
//   pc_out..r7_out           bus source selects
//                            (priority mdr > pc > zhi > zlo > r3 > r4 > r7)
//   *_enable                 register load enables
//   pc_increment             PC <= PC + 1 when pc_enable is low
//   read                     MDR loads m_data_in instead of the bus
//   op_code[4:0]             ALU operation select
//   m_data_in[31:0]          memory read data
//   bus_data, *_data[31:0]   observation of the bus and of every register
module datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic        pc_out,
  input  logic        zhi_out,
  input  logic        zlo_out,
  input  logic        mdr_out,
  input  logic        r3_out,
  input  logic        r4_out,
  input  logic        r7_out,
  input  logic        pc_enable,
  input  logic        mar_enable,
  input  logic        mdr_enable,
  input  logic        ir_enable,
  input  logic        y_enable,
  input  logic        z_enable,
  input  logic        r3_enable,
  input  logic        r4_enable,
  input  logic        r7_enable,
  input  logic        pc_increment,
  input  logic        read,
  input  logic [4:0]  op_code,
  input  logic [31:0] m_data_in,
  output logic [31:0] bus_data,
  output logic [31:0] pc_data,
  output logic [31:0] mar_data,
  output logic [31:0] mdr_data,
  output logic [31:0] ir_data,
  output logic [31:0] y_data,
  output logic [31:0] zhi_data,
  output logic [31:0] zlo_data,
  output logic [31:0] r3_data,
  output logic [31:0] r4_data,
  output logic [31:0] r7_data
);

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [DATA_W-1:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
  logic [DATA_W-1:0] y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [DATA_W-1:0] r3_q, r3_d, r4_q, r4_d, r7_q, r7_d;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_hi, alu_lo;
  logic [4:0]        sh_amt;

  // Duplicating the word makes a rotate a plain shift of a 64-bit value.
  function automatic logic [DATA_W-1:0] rot_right(input logic [DATA_W-1:0] a,
                                                  input logic [4:0] s);
    logic [2*DATA_W-1:0] w;
    w = {a, a} >> s;
    return w[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] rot_left(input logic [DATA_W-1:0] a,
                                                 input logic [4:0] s);
    logic [2*DATA_W-1:0] w;
    w = {a, a} << s;
    return w[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [2*DATA_W-1:0] mul_signed(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] sa, sb, p;
    sa = {{DATA_W{a[DATA_W-1]}}, a};
    sb = {{DATA_W{b[DATA_W-1]}}, b};
    p  = sa * sb;
    return p;
  endfunction

  // Done at double width so that MIN / -1 wraps cleanly to MIN instead of
  // overflowing. Division by zero yields all zeros.
  function automatic logic [2*DATA_W-1:0] div_signed(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] sa, sb, q, r;
    if (b == '0) return '0;
    sa = {{DATA_W{a[DATA_W-1]}}, a};
    sb = {{DATA_W{b[DATA_W-1]}}, b};
    q  = sa / sb;
    r  = sa % sb;
    return {r[DATA_W-1:0], q[DATA_W-1:0]};
  endfunction

  always_comb begin
    bus = '0;
    if (mdr_out)      bus = mdr_q;
    else if (pc_out)  bus = pc_q;
    else if (zhi_out) bus = zhi_q;
    else if (zlo_out) bus = zlo_q;
    else if (r3_out)  bus = r3_q;
    else if (r4_out)  bus = r4_q;
    else if (r7_out)  bus = r7_q;
  end

  assign sh_amt = bus[4:0];

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    case (op_code)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: alu_lo = y_q + bus;
      OP_SUB:           alu_lo = y_q - bus;
      OP_AND, OP_ANDI:  alu_lo = y_q & bus;
      OP_OR, OP_ORI:    alu_lo = y_q | bus;
      OP_ROR:           alu_lo = rot_right(y_q, sh_amt);
      OP_ROL:           alu_lo = rot_left(y_q, sh_amt);
      OP_SHR:           alu_lo = y_q >> sh_amt;
      OP_SHRA:          alu_lo = $signed(y_q) >>> sh_amt;
      OP_SHL:           alu_lo = y_q << sh_amt;
      OP_DIV:           {alu_hi, alu_lo} = div_signed(y_q, bus);
      OP_MUL:           {alu_hi, alu_lo} = mul_signed(y_q, bus);
      OP_NEG:           alu_lo = '0 - bus;
      OP_NOT:           alu_lo = ~bus;
      default: begin
        alu_hi = '0;
        alu_lo = '0;
      end
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    ir_d  = ir_q;
    y_d   = y_q;
    zhi_d = zhi_q;
    zlo_d = zlo_q;
    r3_d  = r3_q;
    r4_d  = r4_q;
    r7_d  = r7_q;
    if (pc_enable)         pc_d = bus;
    else if (pc_increment) pc_d = pc_q + 32'd1;
    if (mar_enable) mar_d = bus;
    if (mdr_enable) mdr_d = read ? m_data_in : bus;
    if (ir_enable)  ir_d  = bus;
    if (y_enable)   y_d   = bus;
    if (z_enable)   {zhi_d, zlo_d} = {alu_hi, alu_lo};
    if (r3_enable)  r3_d  = bus;
    if (r4_enable)  r4_d  = bus;
    if (r7_enable)  r7_d  = bus;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      r3_q  <= '0;
      r4_q  <= '0;
      r7_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
      y_q   <= y_d;
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
      r3_q  <= r3_d;
      r4_q  <= r4_d;
      r7_q  <= r7_d;
    end
  end

  assign bus_data = bus;
  assign pc_data  = pc_q;
  assign mar_data = mar_q;
  assign mdr_data = mdr_q;
  assign ir_data  = ir_q;
  assign y_data   = y_q;
  assign zhi_data = zhi_q;
  assign zlo_data = zlo_q;
  assign r3_data  = r3_q;
  assign r4_data  = r4_q;
  assign r7_data  = r7_q;

endmodule

// File: tb/tb_datapath.sv
`timescale 1ns/1ps
// tb_datapath -- directed and randomized checks of the datapath against a
// behavioural model of the register file, bus priority and ALU.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic        pc_out, zhi_out, zlo_out, mdr_out, r3_out, r4_out, r7_out;
  logic        pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
  logic        r3_enable, r4_enable, r7_enable, pc_increment, read;
  logic [4:0]  op_code;
  logic [31:0] m_data_in;
  logic [31:0] bus_data, pc_data, mar_data, mdr_data, ir_data, y_data;
  logic [31:0] zhi_data, zlo_data, r3_data, r4_data, r7_data;

  always #5 clk = ~clk;

  datapath dut (
    .clk(clk), .clr(clr),
    .pc_out(pc_out), .zhi_out(zhi_out), .zlo_out(zlo_out), .mdr_out(mdr_out),
    .r3_out(r3_out), .r4_out(r4_out), .r7_out(r7_out),
    .pc_enable(pc_enable), .mar_enable(mar_enable), .mdr_enable(mdr_enable),
    .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
    .r3_enable(r3_enable), .r4_enable(r4_enable), .r7_enable(r7_enable),
    .pc_increment(pc_increment), .read(read), .op_code(op_code),
    .m_data_in(m_data_in),
    .bus_data(bus_data), .pc_data(pc_data), .mar_data(mar_data),
    .mdr_data(mdr_data), .ir_data(ir_data), .y_data(y_data),
    .zhi_data(zhi_data), .zlo_data(zlo_data), .r3_data(r3_data),
    .r4_data(r4_data), .r7_data(r7_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model register state.
  logic [31:0] m_pc, m_mar, m_mdr, m_ir, m_y, m_zhi, m_zlo, m_r3, m_r4, m_r7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_bus();
    logic        sel [7];
    logic [31:0] val [7];
    sel = '{mdr_out, pc_out, zhi_out, zlo_out, r3_out, r4_out, r7_out};
    val = '{m_mdr, m_pc, m_zhi, m_zlo, m_r3, m_r4, m_r7};
    for (int i = 0; i < 7; i++) if (sel[i]) return val[i];
    return 32'd0;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] lo, hi;
    int          s, ia, ib;
    longint      sa, sb, q, r;
    lo = 32'd0;
    hi = 32'd0;
    s  = int'(b[4:0]);
    ia = a;
    ib = b;
    sa = longint'(ia);
    sb = longint'(ib);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: lo = a + b;
      5'd4:         lo = a - b;
      5'd5, 5'd13:  lo = a & b;
      5'd6, 5'd14:  lo = a | b;
      5'd7:  begin lo = a; repeat (s) lo = {lo[0], lo[31:1]}; end
      5'd8:  begin lo = a; repeat (s) lo = {lo[30:0], lo[31]}; end
      5'd9:         lo = a >> s;
      5'd10: begin lo = a; repeat (s) lo = {lo[31], lo[31:1]}; end
      5'd11:        lo = a << s;
      5'd15: if (b != 32'd0) begin
        q  = sa / sb;
        r  = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
      end
      5'd16: begin q = sa * sb; {hi, lo} = q; end
      5'd17:        lo = 32'd0 - b;
      5'd18:        lo = ~b;
      default: begin lo = 32'd0; hi = 32'd0; end
    endcase
    return {hi, lo};
  endfunction

  task automatic model_clear();
    {m_pc, m_mar, m_mdr, m_ir, m_y} = '0;
    {m_zhi, m_zlo, m_r3, m_r4, m_r7} = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bus"}, bus_data, ref_bus());
    check({tag, ".pc"},  pc_data,  m_pc);
    check({tag, ".mar"}, mar_data, m_mar);
    check({tag, ".mdr"}, mdr_data, m_mdr);
    check({tag, ".ir"},  ir_data,  m_ir);
    check({tag, ".y"},   y_data,   m_y);
    check({tag, ".zhi"}, zhi_data, m_zhi);
    check({tag, ".zlo"}, zlo_data, m_zlo);
    check({tag, ".r3"},  r3_data,  m_r3);
    check({tag, ".r4"},  r4_data,  m_r4);
    check({tag, ".r7"},  r7_data,  m_r7);
  endtask

  task automatic clear_ctrl();
    {pc_out, zhi_out, zlo_out, mdr_out, r3_out, r4_out, r7_out} = '0;
    {pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable} = '0;
    {r3_enable, r4_enable, r7_enable, pc_increment, read} = '0;
    op_code   = 5'd0;
    m_data_in = 32'd0;
  endtask

  // One clock edge: the model computes from the pre-edge state, then
  // every output is compared just after the edge.
  task automatic tick(input string tag);
    logic [31:0] b;
    logic [63:0] z;
    b = ref_bus();
    z = ref_alu(op_code, m_y, b);
    @(posedge clk);
    #1;
    if (clr) model_clear();
    else begin
      if (pc_enable)         m_pc = b;
      else if (pc_increment) m_pc = m_pc + 32'd1;
      if (mar_enable) m_mar = b;
      if (mdr_enable) m_mdr = read ? m_data_in : b;
      if (ir_enable)  m_ir  = b;
      if (y_enable)   m_y   = b;
      if (z_enable)   {m_zhi, m_zlo} = z;
      if (r3_enable)  m_r3  = b;
      if (r4_enable)  m_r4  = b;
      if (r7_enable)  m_r7  = b;
    end
    check_all(tag);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clear_ctrl();
    read = 1'b1; mdr_enable = 1'b1; m_data_in = v;
    tick("mdr_load");
    clear_ctrl();
  endtask

  initial begin
    clr = 1'b1;
    clear_ctrl();
    model_clear();
    #3;
    check_all("reset");
    // Loads and increments presented while clr is held must be ignored.
    pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; r4_enable = 1'b1;
    tick("reset_ignore");
    clr = 1'b0;
    clear_ctrl();

    // Fetch sequence from reset.
    pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1;
    tick("fetch1");
    check("fetch1_mar", mar_data, 32'h0);
    check("fetch1_pc", pc_data, 32'h1);
    clear_ctrl(); pc_out = 1'b1; r4_enable = 1'b1;
    tick("fetch2");
    check("fetch2_r4", r4_data, 32'h1);
    clear_ctrl(); r4_out = 1'b1; pc_enable = 1'b1;
    tick("fetch3");
    check("fetch3_pc", pc_data, 32'h1);

    // Register loads through MDR.
    load_mdr(32'h22); mdr_out = 1'b1; r3_enable = 1'b1; tick("ld_r3");
    check("ld_r3_val", r3_data, 32'h22);
    load_mdr(32'h24); mdr_out = 1'b1; r7_enable = 1'b1; tick("ld_r7");
    check("ld_r7_val", r7_data, 32'h24);
    load_mdr(32'h28); mdr_out = 1'b1; r4_enable = 1'b1; tick("ld_r4");
    check("ld_r4_val", r4_data, 32'h28);
    load_mdr(32'h1A1B8000); mdr_out = 1'b1; ir_enable = 1'b1; tick("ld_ir");
    check("ld_ir_val", ir_data, 32'h1A1B8000);

    // add: Y=R3, bus=R7.
    clear_ctrl(); r3_out = 1'b1; y_enable = 1'b1; tick("add_y");
    clear_ctrl(); r7_out = 1'b1; op_code = 5'b00011; z_enable = 1'b1; tick("add_z");
    check("add_zlo", zlo_data, 32'h46);
    check("add_zhi", zhi_data, 32'h0);
    clear_ctrl(); zlo_out = 1'b1; r4_enable = 1'b1; tick("add_r4");
    check("add_r4_val", r4_data, 32'h46);

    // mul and div.
    load_mdr(32'hFFFFFFFE); mdr_out = 1'b1; y_enable = 1'b1; tick("mul_y");
    load_mdr(32'd3); mdr_out = 1'b1; op_code = 5'b10000; z_enable = 1'b1; tick("mul_z");
    check("mul_zhi", zhi_data, 32'hFFFFFFFF);
    check("mul_zlo", zlo_data, 32'hFFFFFFFA);
    load_mdr(32'd7); mdr_out = 1'b1; y_enable = 1'b1; tick("div_y");
    load_mdr(32'd2); mdr_out = 1'b1; op_code = 5'b01111; z_enable = 1'b1; tick("div_z");
    check("div_zlo", zlo_data, 32'd3);
    check("div_zhi", zhi_data, 32'd1);
    load_mdr(32'd0); mdr_out = 1'b1; op_code = 5'b01111; z_enable = 1'b1; tick("div0_z");
    check("div0_zlo", zlo_data, 32'd0);
    check("div0_zhi", zhi_data, 32'd0);

    // PC wrap and pc_enable priority over pc_increment.
    load_mdr(32'hFFFFFFFF); mdr_out = 1'b1; pc_enable = 1'b1; tick("pc_max");
    clear_ctrl(); pc_increment = 1'b1; tick("pc_wrap");
    check("pc_wrap_val", pc_data, 32'd0);
    load_mdr(32'd5); mdr_out = 1'b1; pc_enable = 1'b1; pc_increment = 1'b1; tick("pc_prio");
    check("pc_prio_val", pc_data, 32'd5);

    // Bus priority, self reload and a fan-out load.
    clear_ctrl(); mdr_out = 1'b1; pc_out = 1'b1; r7_out = 1'b1; #1;
    check("bus_prio", bus_data, 32'd5);
    clear_ctrl(); r3_out = 1'b1; r3_enable = 1'b1; tick("self_reload");
    clear_ctrl(); r4_out = 1'b1; r3_enable = 1'b1; r7_enable = 1'b1; y_enable = 1'b1;
    tick("fanout");

    // Asynchronous clear between edges.
    clear_ctrl();
    #1 clr = 1'b1;
    #1 model_clear();
    check_all("async_clr");
    check("async_clr_r3", r3_data, 32'd0);
    check("async_clr_ir", ir_data, 32'd0);
    clr = 1'b0;

    // Randomized operation.
    for (int i = 0; i < 400; i++) begin
      clear_ctrl();
      clr          = ($urandom_range(0, 49) == 0);
      pc_out       = ($urandom_range(0, 3) == 0);
      zhi_out      = ($urandom_range(0, 3) == 0);
      zlo_out      = ($urandom_range(0, 3) == 0);
      mdr_out      = ($urandom_range(0, 3) == 0);
      r3_out       = ($urandom_range(0, 3) == 0);
      r4_out       = ($urandom_range(0, 3) == 0);
      r7_out       = ($urandom_range(0, 3) == 0);
      pc_enable    = ($urandom_range(0, 3) == 0);
      mar_enable   = ($urandom_range(0, 2) == 0);
      mdr_enable   = ($urandom_range(0, 2) == 0);
      ir_enable    = ($urandom_range(0, 2) == 0);
      y_enable     = ($urandom_range(0, 2) == 0);
      z_enable     = ($urandom_range(0, 1) == 0);
      r3_enable    = ($urandom_range(0, 2) == 0);
      r4_enable    = ($urandom_range(0, 2) == 0);
      r7_enable    = ($urandom_range(0, 2) == 0);
      pc_increment = ($urandom_range(0, 1) == 0);
      read         = ($urandom_range(0, 1) == 0);
      op_code      = 5'($urandom_range(0, 31));
      m_data_in    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      tick("rand");
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
